instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Instruction fetch controller for the 8-bit core: owns the program counter, drives the byte address of the combinational 4-byte instruction ROM, and captures each 32-bit instruction word into a 2-entry buffer. It delivers the buffered words to the decoder over a valid/ready handshake. It also handles control-flow redirects from the execute stage and stops fetching on a halt opcode. It sits between the instruction ROM and the decode stage.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- HALT_OPCODE, 8'hFF, first-byte opcode treated as halt (only with halt detection compiled in)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  fetch enable from top-level control
- rom_addr  out  8  byte address to instruction ROM; equals the current PC
- rom_b1..rom_b4  in  8 each  ROM bytes at rom_addr+0..+3; rom_b1 is the most significant
- instr  out  32  head-of-buffer word, {b1,b2,b3,b4}
- instr_pc  out  8  address the head word was fetched from
- instr_valid  out  1  head word valid
- instr_ready  in  1  decoder accepts head word
- redirect  in  1  one-cycle pulse: flush buffer and jump
- redirect_pc  in  8  jump target
- halted  out  1  halt reached and buffer drained
- fetch_count  out  16  words pushed since reset; saturates at 16'hFFFF

## Operation
- States:
  - IDLE: no fetch.
  - FETCH: push one word per cycle while space is available.
  - HALT: no fetch.
- Transitions:
  - IDLE→FETCH when run=1.
  - FETCH→IDLE when run=0.
  - FETCH→HALT on a halt push (see Configuration).
  - HALT→FETCH on redirect if run=1, else HALT→IDLE on redirect.
  - IDLE ignores run while redirect is asserted; the redirect is applied first.
- Buffer: 2-entry FIFO of {pc, word}; count 0..2.
  - Pop occurs when instr_valid && instr_ready.
  - Push occurs in FETCH when count<2, or when count==2 and a pop happens that same cycle.
  - Push and pop may occur in the same cycle; count is then unchanged.
- PC advance: PC ← PC+4 on each push. Arithmetic is 8-bit modulo 256, so 8'hFC advances to 8'h00.
- Redirect has highest priority. In the redirect cycle:
  - Any pop completes.
  - The buffer is then cleared and no push occurs.
  - PC ← redirect_pc.
  - The state leaves HALT as above.
- run=0 stops pushes only. Buffered words stay deliverable and the PC holds.
- instr_valid = (count≠0). instr and instr_pc always show the head entry; both are 0 when the buffer is empty.
- halted = (state==HALT && count==0).
- fetch_count increments on each push and saturates; redirect does not clear it.

## Timing
- Reset values:
  - rom_addr = RESET_PC, with PC = RESET_PC.
  - instr = 0, instr_pc = 0, instr_valid = 0.
  - halted = 0, fetch_count = 0.
  - State = IDLE, count = 0.
- rom_addr is driven combinationally from the registered PC. The ROM word is sampled at the same edge that performs the push.
- Latency:
  - The first edge with run=1 performs IDLE→FETCH; there is no push on that edge.
  - The first push occurs on the next edge.
  - instr_valid goes high 2 cycles after run rises.
- Throughput: 1 word/cycle with instr_ready held high.
- Redirect: instr_valid is low the cycle after the redirect edge. A word from redirect_pc is pushed on the following edge, giving 2-cycle redirect latency.
- Reset asserted mid-operation clears all state immediately, with no completion of a pending push or pop.

## Configuration
- FETCH_HALT_DETECT_EN
  - Defined: a push whose rom_b1==HALT_OPCODE pushes that word normally, then the FSM enters HALT and pushes stop. halted rises once the decoder has popped the halt word.
  - Undefined: HALT_OPCODE is ignored. The HALT state is unreachable and halted is tied to 0.

## Test plan
- Reset release, run=1, ready=1, ROM words W0..W3 at 0,4,8,12 -> instr_valid high 2 cycles after run; words W0,W1,W2,W3 on consecutive cycles with instr_pc 0,4,8,12; fetch_count=4 after the 4th push.
- ready=0 for 5 cycles after the first push -> exactly 2 words buffered; PC stops at 8; instr holds W0; releasing ready yields W0,W1,W2 in order with no loss or duplication.
- Start at RESET_PC=8'hF8, ready=1 -> instr_pc sequence F8, FC, 00, 04 (PC wrap).
- Redirect to 8'h40 while 2 words are buffered and a pop occurs in the same cycle -> the popped word is accepted, the other is discarded, instr_valid is low for one cycle, then the word at 8'h40 is presented with instr_pc=40.
- With FETCH_HALT_DETECT_EN, 8'hFF as b1 at address 8 -> words at 0,4,8 delivered, none from 12; halted=1 the cycle after the halt word pops; redirect to 0 clears halted and restarts fetch.
- Assert reset while instr_valid=1 and count=2 -> all outputs return to reset values immediately; fetch resumes from RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Instruction fetch controller for the 8-bit core. Owns the program counter,
// drives the byte address of the combinational 4-byte instruction ROM and
// captures each 32-bit word into a 2-entry {pc, word} FIFO that is handed to
// the decoder over a valid/ready handshake. Execute-stage redirects flush the
// FIFO and reload the PC; an optional halt opcode stops fetching.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   defined   : a pushed word whose first byte equals HALT_OPCODE moves the
//               FSM to HALT after that push; o_halted rises once it drains.
//   undefined : HALT_OPCODE is ignored, HALT is unreachable, o_halted = 0.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_run            fetch enable
//   o_rom_addr       ROM byte address (current PC)
//   i_rom_b1..b4     ROM bytes at addr+0..+3, b1 most significant
//   o_instr          head-of-buffer word (0 when empty)
//   o_instr_pc       fetch address of the head word (0 when empty)
//   o_instr_valid    head word valid
//   i_instr_ready    decoder accepts the head word
//   i_redirect       one-cycle flush-and-jump pulse
//   i_redirect_pc    jump target
//   o_halted         halt reached and buffer drained
//   o_fetch_count    saturating count of pushed words since reset
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  output logic [7:0]  o_rom_addr,
  input  logic [7:0]  i_rom_b1,
  input  logic [7:0]  i_rom_b2,
  input  logic [7:0]  i_rom_b3,
  input  logic [7:0]  i_rom_b4,
  output logic [31:0] o_instr,
  output logic [7:0]  o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [7:0]  i_redirect_pc,
  output logic        o_halted,
  output logic [15:0] o_fetch_count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_pc, w_pc_d;
  logic [1:0]  r_count, w_count_d;
  // Entry 0 is always the head; entry 1 is kept at zero when not occupied so
  // the head reads back as zero once the buffer empties.
  logic [7:0]  r_pc0, r_pc1, w_pc0_d, w_pc1_d;
  logic [31:0] r_word0, r_word1, w_word0_d, w_word1_d;
  logic [15:0] r_fetch_count, w_fetch_count_d;

  logic [31:0] w_rom_word;
  logic        w_pop;
  logic        w_space;
  logic        w_push;
  logic        w_halt_hit;

  assign w_rom_word = {i_rom_b1, i_rom_b2, i_rom_b3, i_rom_b4};
  assign w_pop      = (r_count != 2'd0) && i_instr_ready;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_space    = (r_count != 2'd2) || w_pop;
  assign w_push     = (r_state == StFetch) && i_run && !i_redirect && w_space;

`ifdef FETCH_HALT_DETECT_EN
  assign w_halt_hit = w_push && (i_rom_b1 == HALT_OPCODE);
`else
  logic w_unused_halt_opcode;
  assign w_unused_halt_opcode = ^HALT_OPCODE;
  assign w_halt_hit = 1'b0;
`endif

  // FSM next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        // A redirect is applied before run is considered.
        if (!i_redirect && i_run) w_state_d = StFetch;
      end
      StFetch: begin
        if (!i_run)          w_state_d = StIdle;
        else if (w_halt_hit) w_state_d = StHalt;
      end
      StHalt: begin
        if (i_redirect) w_state_d = i_run ? StFetch : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Buffer, PC and counter next state
  always_comb begin
    w_count_d       = r_count;
    w_pc0_d         = r_pc0;
    w_pc1_d         = r_pc1;
    w_word0_d       = r_word0;
    w_word1_d       = r_word1;
    w_pc_d          = r_pc;
    w_fetch_count_d = r_fetch_count;

    if (i_redirect) begin
      // Any pop this cycle is already complete from the decoder's view; the
      // remaining contents are dropped.
      w_count_d = 2'd0;
      w_pc0_d   = 8'h00;
      w_pc1_d   = 8'h00;
      w_word0_d = 32'h0;
      w_word1_d = 32'h0;
      w_pc_d    = i_redirect_pc;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_pc0_d   = r_pc;
            w_word0_d = w_rom_word;
          end else begin
            w_pc1_d   = r_pc;
            w_word1_d = w_rom_word;
          end
          w_count_d = r_count + 2'd1;
        end
        2'b01: begin
          w_pc0_d   = r_pc1;
          w_word0_d = r_word1;
          w_pc1_d   = 8'h00;
          w_word1_d = 32'h0;
          w_count_d = r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            w_pc0_d   = r_pc;
            w_word0_d = w_rom_word;
          end else begin
            w_pc0_d   = r_pc1;
            w_word0_d = r_word1;
            w_pc1_d   = r_pc;
            w_word1_d = w_rom_word;
          end
        end
        default: ;
      endcase

      if (w_push) w_pc_d = r_pc + 8'd4;
    end

    if (w_push && (r_fetch_count != 16'hFFFF)) begin
      w_fetch_count_d = r_fetch_count + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_count       <= 2'd0;
      r_pc0         <= 8'h00;
      r_pc1         <= 8'h00;
      r_word0       <= 32'h0;
      r_word1       <= 32'h0;
      r_fetch_count <= 16'h0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_count       <= w_count_d;
      r_pc0         <= w_pc0_d;
      r_pc1         <= w_pc1_d;
      r_word0       <= w_word0_d;
      r_word1       <= w_word1_d;
      r_fetch_count <= w_fetch_count_d;
    end
  end

  assign o_rom_addr    = r_pc;
  assign o_instr       = r_word0;
  assign o_instr_pc    = r_pc0;
  assign o_instr_valid = (r_count != 2'd0);
  assign o_fetch_count = r_fetch_count;

`ifdef FETCH_HALT_DETECT_EN
  assign o_halted = (r_state == StHalt) && (r_count == 2'd0);
`else
  assign o_halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  rpc = 8'h00;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_b1, rom_b2, rom_b3, rom_b4;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0] rom [256];
  logic [7:0] a1, a2, a3;

  assign a1 = rom_addr + 8'd1;
  assign a2 = rom_addr + 8'd2;
  assign a3 = rom_addr + 8'd3;
  assign rom_b1 = rom[rom_addr];
  assign rom_b2 = rom[a1];
  assign rom_b3 = rom[a2];
  assign rom_b4 = rom[a3];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .RESET_PC   (8'h00),
    .HALT_OPCODE(8'hFF)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_run         (run),
    .o_rom_addr    (rom_addr),
    .i_rom_b1      (rom_b1),
    .i_rom_b2      (rom_b2),
    .i_rom_b3      (rom_b3),
    .i_rom_b4      (rom_b4),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_valid (instr_valid),
    .i_instr_ready (ready),
    .i_redirect    (redirect),
    .i_redirect_pc (rpc),
    .o_halted      (halted),
    .o_fetch_count (fetch_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = a;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {rom[b0], rom[b1], rom[b2], rom[b3]};
  endfunction

  // Reference model: the buffer is a queue of expected {pc, word} entries that
  // also serves as the scoreboard the monitor consumes.
  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] word;
  } ent_t;

  ent_t        mq[$];
  logic [7:0]  mpc = 8'h00;
  bit          mfetch = 1'b0;
  bit          mhalt = 1'b0;
  int unsigned mcnt = 0;

  always @(posedge clk or posedge reset) begin
    ent_t e;
    if (reset) begin
      mq.delete();
      mpc    = 8'h00;
      mfetch = 1'b0;
      mhalt  = 1'b0;
      mcnt   = 0;
    end else if (redirect) begin
      mq.delete();
      mpc = rpc;
      if (mhalt) begin
        mhalt  = 1'b0;
        mfetch = run;
      end else begin
        mfetch = mfetch && run;
      end
    end else if (mhalt) begin
      // halted: nothing moves until a redirect
    end else if (!mfetch) begin
      mfetch = run;
    end else if (!run) begin
      mfetch = 1'b0;
    end else if (mq.size() < 2) begin
      e.pc   = mpc;
      e.word = rom_word(mpc);
      mq.push_back(e);
      mpc = mpc + 8'd4;
      if (mcnt < 65535) mcnt++;
      if (HaltEn && e.word[31:24] == 8'hFF) begin
        mfetch = 1'b0;
        mhalt  = 1'b1;
      end
    end
  end

  // Monitor: samples on the falling edge, compares the DUT head against the
  // scoreboard head and retires it when the decoder accepts.
  always @(negedge clk) begin
    if (!reset) begin
      check("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      check("halted", 32'(halted), 32'(mhalt && mq.size() == 0));
      check("rom_addr", 32'(rom_addr), 32'(mpc));
      check("fetch_count", 32'(fetch_count), mcnt);
      if (mq.size() != 0) begin
        check("instr", instr, mq[0].word);
        check("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
        if (ready) void'(mq.pop_front());
      end else begin
        check("instr_empty", instr, 32'h0);
        check("instr_pc_empty", 32'(instr_pc), 32'h0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 254));
    reset = 1'b1;
    step(3);
    #1;
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_addr", 32'(rom_addr), 32'h0);
    reset = 1'b0;
    step(2);

    // streaming from reset
    run = 1'b1;
    ready = 1'b1;
    step(8);

    // decoder stall fills the buffer, then drains in order
    ready = 1'b0;
    step(5);
    ready = 1'b1;
    step(4);

    // PC wrap through FC -> 00
    redirect = 1'b1;
    rpc = 8'hF8;
    step(1);
    redirect = 1'b0;
    step(8);

    // redirect with a full buffer and a pop in the same cycle
    ready = 1'b0;
    step(4);
    ready = 1'b1;
    redirect = 1'b1;
    rpc = 8'h40;
    step(1);
    redirect = 1'b0;
    step(5);

    // run low: buffered words stay deliverable, PC holds
    run = 1'b0;
    ready = 1'b0;
    step(3);
    ready = 1'b1;
    step(3);
    run = 1'b1;
    step(3);

    // random traffic
    repeat (400) begin
      run = ($urandom_range(0, 9) != 0);
      ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 11) == 0);
      rpc = 8'($urandom);
      step(1);
    end
    redirect = 1'b0;

`ifdef FETCH_HALT_DETECT_EN
    // halt opcode at address 8, then restart by redirect
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    rom[8] = 8'hFF;
    run = 1'b1;
    ready = 1'b1;
    step(10);
    check("halt_reached", 32'(halted), 32'h1);
    redirect = 1'b1;
    rpc = 8'h00;
    step(1);
    redirect = 1'b0;
    step(3);
    repeat (20) begin
      ready = 1'($urandom_range(0, 1));
      step(1);
    end
    ready = 1'b1;
    step(4);
    rom[8] = 8'h00;
`endif

    // reset while the buffer is full
    run = 1'b1;
    ready = 1'b0;
    step(4);
    check("pre_rst_valid", 32'(instr_valid), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(instr_valid), 32'h0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_pc", 32'(instr_pc), 32'h0);
    check("mid_rst_addr", 32'(rom_addr), 32'h0);
    check("mid_rst_count", 32'(fetch_count), 32'h0);
    check("mid_rst_halted", 32'(halted), 32'h0);
    step(2);
    reset = 1'b0;
    ready = 1'b1;
    step(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
